// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl -- pipeline stall/flush controller for the MIPS32 core.
//
// Works beside the EXE-stage forwarding unit and handles the hazards that
// forwarding cannot cover:
//   * load-use: one bubble while the loaded value is still in flight,
//   * multi-cycle mul/div: holds the front end for MDU_LATENCY cycles,
//   * taken branch resolved in EXE: flushes IF/ID and bubbles ID/EXE.
//
// Ports:
//   CLK, RST                 clock (rising edge), async active-high reset
//   SOURCE1_ID, SOURCE2_ID   rs / rt of the instruction in ID
//   TWO_SRC_ID               ID instruction actually reads rt
//   DESTINATION_EXE          destination register of the EXE instruction
//   MEM_READ_EXE             EXE instruction is a load
//   MDU_START_ID             ID instruction is mul/div
//   BRANCH_TAKEN_EXE         taken branch/jump resolved in EXE
//   PC_WRITE_EN              PC register enable
//   IF_ID_WRITE_EN           IF/ID register enable
//   ID_EXE_BUBBLE            load a NOP into ID/EXE
//   IF_ID_FLUSH              clear IF/ID to a NOP
//   MDU_BUSY                 mul/div wait sequence in progress
//
// Optional build macro HAZARD_STATS_EN adds two free-running 32-bit
// counters: STALL_CYCLES (cycles with PC held) and FLUSH_COUNT (cycles
// with IF/ID flushed). Both are cleared by RST and wrap.

module hazard_stall_ctrl #(
  parameter int REG_ADDR_LEN = 5,
  parameter int MDU_LATENCY  = 4   // legal range 1..15
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [REG_ADDR_LEN-1:0] SOURCE1_ID,
  input  logic [REG_ADDR_LEN-1:0] SOURCE2_ID,
  input  logic                    TWO_SRC_ID,
  input  logic [REG_ADDR_LEN-1:0] DESTINATION_EXE,
  input  logic                    MEM_READ_EXE,
  input  logic                    MDU_START_ID,
  input  logic                    BRANCH_TAKEN_EXE,
  output logic                    PC_WRITE_EN,
  output logic                    IF_ID_WRITE_EN,
  output logic                    ID_EXE_BUBBLE,
  output logic                    IF_ID_FLUSH,
  output logic                    MDU_BUSY
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]             STALL_CYCLES,
  output logic [31:0]             FLUSH_COUNT
`endif
);

  // Two of the four encodings are unused; the default arm maps them to RUN.
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MDU_WAIT = 2'b01
  } state_e;

  // The RUN cycle that launches the mul/div is not part of the wait, so the
  // counter is loaded with LATENCY-1 and the wait ends on the cycle it reads 0.
  localparam logic [3:0] MDU_LOAD = 4'(MDU_LATENCY - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;

  logic pc_write_en, if_id_write_en, id_exe_bubble, if_id_flush, mdu_busy;

  // $zero is hard-wired, so a load targeting it can never create a hazard.
  assign load_use = MEM_READ_EXE && (DESTINATION_EXE != '0) &&
                    ((SOURCE1_ID == DESTINATION_EXE) ||
                     (TWO_SRC_ID && (SOURCE2_ID == DESTINATION_EXE)));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    id_exe_bubble  = 1'b0;
    if_id_flush    = 1'b0;
    mdu_busy       = 1'b0;

    unique case (state_q)
      RUN: begin
        if (BRANCH_TAKEN_EXE) begin
          // Wrong-path instructions in IF and ID are both discarded; the held
          // hazards go with them, so load_use / MDU_START_ID are moot.
          id_exe_bubble = 1'b1;
          if_id_flush   = 1'b1;
        end else if (load_use) begin
          // One bubble suffices: next cycle the load sits in MEM and the
          // forwarding unit supplies the value. A pending mul/div in ID is
          // simply held and re-evaluated next cycle.
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          id_exe_bubble  = 1'b1;
        end else if (MDU_START_ID) begin
          state_d = MDU_WAIT;
          cnt_d   = MDU_LOAD;
        end
      end
      MDU_WAIT: begin
        mdu_busy       = 1'b1;
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_exe_bubble  = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    // Reset must quiesce the pipeline immediately, not on the next edge.
    if (RST) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_exe_bubble  = 1'b1;
      if_id_flush    = 1'b1;
      mdu_busy       = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC_WRITE_EN    = pc_write_en;
  assign IF_ID_WRITE_EN = if_id_write_en;
  assign ID_EXE_BUBBLE  = id_exe_bubble;
  assign IF_ID_FLUSH    = if_id_flush;
  assign MDU_BUSY       = mdu_busy;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Reset cycles are excluded implicitly: the flops are held clear while RST=1.
  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, ~pc_write_en};
    flush_count_d  = flush_count_q + {31'd0, if_id_flush};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign STALL_CYCLES = stall_cycles_q;
  assign FLUSH_COUNT  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl.
// Inputs change 1 time unit after the rising edge. A reference model tracks
// the number of front-end stall cycles still owed to the MDU and derives the
// expected outputs from the hazard rules; a compare process checks every
// output on every falling edge. Directed sequences add literal expectations.

module tb_hazard_stall_ctrl;

  localparam int AW  = 5;
  localparam int LAT = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] SOURCE1_ID, SOURCE2_ID, DESTINATION_EXE;
  logic          TWO_SRC_ID, MEM_READ_EXE, MDU_START_ID, BRANCH_TAKEN_EXE;
  logic          PC_WRITE_EN, IF_ID_WRITE_EN, ID_EXE_BUBBLE, IF_ID_FLUSH, MDU_BUSY;
`ifdef HAZARD_STATS_EN
  logic [31:0]   STALL_CYCLES, FLUSH_COUNT;
`endif

  hazard_stall_ctrl #(.REG_ADDR_LEN(AW), .MDU_LATENCY(LAT)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .SOURCE1_ID       (SOURCE1_ID),
    .SOURCE2_ID       (SOURCE2_ID),
    .TWO_SRC_ID       (TWO_SRC_ID),
    .DESTINATION_EXE  (DESTINATION_EXE),
    .MEM_READ_EXE     (MEM_READ_EXE),
    .MDU_START_ID     (MDU_START_ID),
    .BRANCH_TAKEN_EXE (BRANCH_TAKEN_EXE),
    .PC_WRITE_EN      (PC_WRITE_EN),
    .IF_ID_WRITE_EN   (IF_ID_WRITE_EN),
    .ID_EXE_BUBBLE    (ID_EXE_BUBBLE),
    .IF_ID_FLUSH      (IF_ID_FLUSH),
    .MDU_BUSY         (MDU_BUSY)
`ifdef HAZARD_STATS_EN
    ,
    .STALL_CYCLES     (STALL_CYCLES),
    .FLUSH_COUNT      (FLUSH_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int          owed_stalls = 0;   // MDU stall cycles still to be served
  int unsigned m_stall = 0, m_flush = 0;

  function automatic bit m_load_use();
    return MEM_READ_EXE && DESTINATION_EXE != 0 &&
           (SOURCE1_ID == DESTINATION_EXE || (TWO_SRC_ID && SOURCE2_ID == DESTINATION_EXE));
  endfunction

  // Expected {pc, ifid, bubble, flush, busy}.
  function automatic logic [4:0] m_out();
    if (RST)                  return 5'b00110;
    if (owed_stalls > 0)      return 5'b00101;
    if (BRANCH_TAKEN_EXE)     return 5'b11110;
    if (m_load_use())         return 5'b00100;
    return 5'b11000;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      owed_stalls = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      logic [4:0] o;
      o = m_out();
      if (!o[4]) m_stall++;
      if (o[1])  m_flush++;
      if (owed_stalls > 0) owed_stalls--;
      else if (!BRANCH_TAKEN_EXE && !m_load_use() && MDU_START_ID) owed_stalls = LAT;
    end
  end

  always @(negedge CLK) begin
    logic [4:0] e;
    e = m_out();
    check("pc_write_en",    {31'd0, PC_WRITE_EN},    {31'd0, e[4]});
    check("if_id_write_en", {31'd0, IF_ID_WRITE_EN}, {31'd0, e[3]});
    check("id_exe_bubble",  {31'd0, ID_EXE_BUBBLE},  {31'd0, e[2]});
    check("if_id_flush",    {31'd0, IF_ID_FLUSH},    {31'd0, e[1]});
    check("mdu_busy",       {31'd0, MDU_BUSY},       {31'd0, e[0]});
`ifdef HAZARD_STATS_EN
    check("stall_cycles", STALL_CYCLES, m_stall);
    check("flush_count",  FLUSH_COUNT,  m_flush);
`endif
  end

  // A taken branch while the MDU holds EXE is a protocol violation.
  always @(negedge CLK) begin
    if (!RST && MDU_BUSY)
      assert (!BRANCH_TAKEN_EXE) else $error("branch taken during MDU wait");
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic two,
                       input logic [AW-1:0] dst, input logic mr, input logic mdu, input logic br);
    @(posedge CLK);
    #1;
    SOURCE1_ID = s1; SOURCE2_ID = s2; TWO_SRC_ID = two; DESTINATION_EXE = dst;
    MEM_READ_EXE = mr; MDU_START_ID = mdu; BRANCH_TAKEN_EXE = br;
    #2;  // let combinational outputs settle before literal checks
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int stalls;
    RST = 1'b1;
    SOURCE1_ID = '0; SOURCE2_ID = '0; TWO_SRC_ID = 1'b0; DESTINATION_EXE = '0;
    MEM_READ_EXE = 1'b0; MDU_START_ID = 1'b0; BRANCH_TAKEN_EXE = 1'b0;

    repeat (2) @(posedge CLK);
    #1;
    check("rst_pc",    {31'd0, PC_WRITE_EN},   32'd0);
    check("rst_flush", {31'd0, IF_ID_FLUSH},   32'd1);
    check("rst_bub",   {31'd0, ID_EXE_BUBBLE}, 32'd1);
    check("rst_busy",  {31'd0, MDU_BUSY},      32'd0);
    RST = 1'b0;

    idle();
    check("idle_pc",  {31'd0, PC_WRITE_EN},   32'd1);
    check("idle_bub", {31'd0, ID_EXE_BUBBLE}, 32'd0);

    // Load-use on rs: one bubble, then forwarding takes over.
    drive(5, 0, 0, 5, 1, 0, 0);
    check("lu_pc",   {31'd0, PC_WRITE_EN},    32'd0);
    check("lu_ifid", {31'd0, IF_ID_WRITE_EN}, 32'd0);
    check("lu_bub",  {31'd0, ID_EXE_BUBBLE},  32'd1);
    check("lu_fl",   {31'd0, IF_ID_FLUSH},    32'd0);
    drive(5, 0, 0, 5, 0, 0, 0);
    check("lu_next_pc",  {31'd0, PC_WRITE_EN},   32'd1);
    check("lu_next_bub", {31'd0, ID_EXE_BUBBLE}, 32'd0);

    // $zero never hazards; rt only matters for two-source instructions.
    drive(0, 0, 0, 0, 1, 0, 0);
    check("zero_pc", {31'd0, PC_WRITE_EN}, 32'd1);
    drive(3, 7, 0, 7, 1, 0, 0);
    check("rt_1src_pc", {31'd0, PC_WRITE_EN}, 32'd1);
    drive(3, 7, 1, 7, 1, 0, 0);
    check("rt_2src_pc", {31'd0, PC_WRITE_EN}, 32'd0);

    // Branch beats load-use and mul/div start.
    drive(5, 0, 0, 5, 1, 1, 1);
    check("br_flush", {31'd0, IF_ID_FLUSH},   32'd1);
    check("br_bub",   {31'd0, ID_EXE_BUBBLE}, 32'd1);
    check("br_pc",    {31'd0, PC_WRITE_EN},   32'd1);
    idle();
    check("br_stay_run", {31'd0, MDU_BUSY}, 32'd0);

    // Single mul: one advance cycle then exactly LAT stall cycles.
    drive(0, 0, 0, 0, 0, 1, 0);
    check("mdu_adv_pc", {31'd0, PC_WRITE_EN}, 32'd1);
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (MDU_BUSY && !PC_WRITE_EN) stalls++;
    end
    check("mdu_stall_len", stalls, 32'd4);

    // Back-to-back mul (held in ID): 4 + 4 stalls separated by one advance.
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      if (i == 0 || i == 5) check("b2b_adv", {31'd0, PC_WRITE_EN}, 32'd1);
      if (MDU_BUSY) stalls++;
    end
    check("b2b_stalls", stalls, 32'd8);
    idle();
    check("b2b_end_busy", {31'd0, MDU_BUSY}, 32'd0);

    // Async reset during the second wait cycle.
    drive(0, 0, 0, 0, 0, 1, 0);
    idle();
    idle();
    RST = 1'b1;
    #1;
    check("arst_busy",  {31'd0, MDU_BUSY},    32'd0);
    check("arst_flush", {31'd0, IF_ID_FLUSH}, 32'd1);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    check("arst_run_pc",   {31'd0, PC_WRITE_EN}, 32'd1);
    check("arst_run_busy", {31'd0, MDU_BUSY},    32'd0);

`ifdef HAZARD_STATS_EN
    @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    check("stat_rst_stall", STALL_CYCLES, 32'd0);
    check("stat_rst_flush", FLUSH_COUNT,  32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    drive(5, 0, 0, 5, 1, 0, 0);
    idle();
    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (4) idle();
    idle();
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    idle();
    check("stat_stall", STALL_CYCLES, 32'd5);
    check("stat_flush", FLUSH_COUNT,  32'd2);
`endif

    repeat (3) idle();
    @(posedge CLK);
    #1;
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard controller for the MIPS32 core; it is the stall/flush companion to the EXE-stage forwarding unit.
- Detects load-use hazards that forwarding cannot cover.
- Holds the front end while the multi-cycle multiply/divide unit (MDU) occupies EXE.
- Flushes IF/ID on a taken branch resolved in EXE.
- Drives PC, IF/ID and ID/EXE register enables. Sits in CONTROL_PATH beside the forwarding logic.

Parameters:
REG_ADDR_LEN, 5, register address width.
MDU_LATENCY, 4, number of front-end stall cycles per mul/div (legal range 1..15).

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  asynchronous, active-high reset.
SOURCE1_ID  input  REG_ADDR_LEN  rs of the instruction in ID.
SOURCE2_ID  input  REG_ADDR_LEN  rt of the instruction in ID.
TWO_SRC_ID  input  1  ID instruction reads SOURCE2_ID (R-type, store, branch).
DESTINATION_EXE  input  REG_ADDR_LEN  destination of the instruction in EXE.
MEM_READ_EXE  input  1  EXE instruction is a load.
MDU_START_ID  input  1  ID instruction is mul/div.
BRANCH_TAKEN_EXE  input  1  taken branch/jump resolved in EXE.
PC_WRITE_EN  output  1  PC register enable.
IF_ID_WRITE_EN  output  1  IF/ID register enable.
ID_EXE_BUBBLE  output  1  load a NOP into ID/EXE.
IF_ID_FLUSH  output  1  clear IF/ID to a NOP.
MDU_BUSY  output  1  MDU sequence in progress.

Behaviour:
State and counter:
- Registered state is RUN or MDU_WAIT, plus a down-counter CNT of 4 bits. All outputs are combinational from state, CNT, RST and inputs.
- While RST=1 (asynchronous): state=RUN, CNT=0. Outputs forced to PC_WRITE_EN=0, IF_ID_WRITE_EN=0, ID_EXE_BUBBLE=1, IF_ID_FLUSH=1, MDU_BUSY=0.
- Reset asserted mid-MDU_WAIT aborts the sequence immediately. After release the block starts in RUN.

load_use (combinational):
- Asserted when MEM_READ_EXE=1 and DESTINATION_EXE≠0 and (SOURCE1_ID==DESTINATION_EXE, or TWO_SRC_ID=1 and SOURCE2_ID==DESTINATION_EXE).
- Register 0 never causes a hazard.

RUN, priority high to low:
- BRANCH_TAKEN_EXE=1: PC_WRITE_EN=1, IF_ID_WRITE_EN=1, IF_ID_FLUSH=1, ID_EXE_BUBBLE=1. load_use and MDU_START_ID are ignored this cycle. Stay in RUN.
- load_use=1: PC_WRITE_EN=0, IF_ID_WRITE_EN=0, ID_EXE_BUBBLE=1, IF_ID_FLUSH=0. Stay in RUN.
  - Exactly one bubble per load-use pair; the next cycle the load is in MEM and forwarding resolves it.
  - MDU_START_ID is deferred with the held instruction.
- MDU_START_ID=1: normal advance this cycle (all enables 1, bubble 0, flush 0); the mul/div enters EXE. Next state MDU_WAIT, CNT<=MDU_LATENCY-1.
- Otherwise: PC_WRITE_EN=1, IF_ID_WRITE_EN=1, ID_EXE_BUBBLE=0, IF_ID_FLUSH=0.

MDU_WAIT:
- Outputs: MDU_BUSY=1, PC_WRITE_EN=0, IF_ID_WRITE_EN=0, ID_EXE_BUBBLE=1, IF_ID_FLUSH=0.
- CNT decrements each cycle. When CNT==0, next state is RUN.
- The wait therefore lasts exactly MDU_LATENCY cycles.
- BRANCH_TAKEN_EXE, load_use and MDU_START_ID are ignored.
- BRANCH_TAKEN_EXE=1 in this state is a protocol violation and is flagged by a bench assertion.
- Back-to-back mul/div: the second is seen in ID on the first RUN cycle and starts a new sequence.

General:
- MDU_BUSY=0 in RUN.
- No X-propagation: all states and CNT values are fully decoded; an unused encoding returns to RUN.

Optional Feature:
Macro HAZARD_STATS_EN.
- Defined: adds output ports STALL_CYCLES [31:0] and FLUSH_COUNT [31:0], both registered and cleared by RST.
  - STALL_CYCLES increments on every cycle with PC_WRITE_EN=0 and RST=0.
  - FLUSH_COUNT increments on every cycle with IF_ID_FLUSH=1 and RST=0.
  - Both wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: MEM_READ_EXE=1, DESTINATION_EXE=5, SOURCE1_ID=5 -> that cycle PC_WRITE_EN=0, IF_ID_WRITE_EN=0, ID_EXE_BUBBLE=1. Next cycle (MEM_READ_EXE=0) all enables 1, bubble 0.
- $zero and single-source: (a) DESTINATION_EXE=0 with SOURCE1_ID=0 and MEM_READ_EXE=1 -> no stall. (b) SOURCE2_ID=7=DESTINATION_EXE with TWO_SRC_ID=0 -> no stall; with TWO_SRC_ID=1 -> stall.
- MDU: MDU_START_ID=1 in RUN with MDU_LATENCY=4 -> advance cycle, then MDU_BUSY=1 and PC_WRITE_EN=0 for exactly 4 cycles, then RUN. Back-to-back mul gives 4+4 stall cycles separated by one advance cycle.
- Branch priority: BRANCH_TAKEN_EXE=1 together with load_use=1 and MDU_START_ID=1 -> IF_ID_FLUSH=1, ID_EXE_BUBBLE=1, PC_WRITE_EN=1, state stays RUN.
- Reset mid-op: assert RST on the 2nd MDU_WAIT cycle, asynchronously -> MDU_BUSY=0 and IF_ID_FLUSH=1 without waiting for a clock edge. After release, first cycle shows RUN outputs.
- HAZARD_STATS_EN: one load-use stall, one 4-cycle MDU sequence and 2 taken branches -> STALL_CYCLES=5, FLUSH_COUNT=2. With RST pulsed -> both read 0.
